// File: rtl/dotmatrix_pkg.sv
// Shared types and constant helpers for the LED dot-matrix scan driver.
package dotmatrix_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Ceiling log2, never below 1 so that derived vectors stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Panel wiring permutation within one 8-column panel.
    function automatic int remap_col(input int c, input bit en);
        if (!en) return c;
        case (c)
            0:       return 7;
            1:       return 6;
            2:       return 1;
            3:       return 2;
            4:       return 0;
            5:       return 4;
            6:       return 5;
            7:       return 3;
            default: return c;
        endcase
    endfunction

endpackage

// File: rtl/dm_frame_buffer.sv
// Double-buffered column store: writes land in the back bank, the front
// bank is read through a registered port that drives the row outputs.
module dm_frame_buffer
    import dotmatrix_pkg::*;
#(
    parameter int N    = 32,
    parameter int ROWS = 16,
    parameter int CW   = 5
) (
    input  logic            Divided_CLK,
    input  logic            RESET,
    input  logic            wr_en,
    input  logic            wr_bank,
    input  logic [CW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    input  logic            rd_bank,
    input  logic [CW-1:0]   rd_addr,
    input  logic            rd_load,
    input  logic            rd_clr,
    output logic [ROWS-1:0] rd_data
);

    logic [ROWS-1:0] bank0 [N];
    logic [ROWS-1:0] bank1 [N];

    // Write port: contents are never reset.
    always_ff @(posedge Divided_CLK) begin
        if (wr_en) begin
            if (wr_bank) bank1[wr_addr] <= wr_data;
            else         bank0[wr_addr] <= wr_data;
        end
    end

    // Read register: loaded during blanking, held through the drive phase,
    // cleared when the drive phase ends so blanking shows all rows off.
    always_ff @(posedge Divided_CLK or posedge RESET) begin
        if (RESET) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_load) begin
            rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: rtl/matrix_scanner.sv
// Column-scan driver for a multi-panel LED matrix: blank/drive scan FSM,
// frame-synchronous bank swap and horizontal scroll.
module matrix_scanner
    import dotmatrix_pkg::*;
#(
    parameter int NUM_PANELS  = 4,
    parameter int COLS        = 8,
    parameter int ROWS        = 16,
    parameter int HOLD_CYCLES = 1,
    parameter bit REMAP_EN    = 1'b1,
    localparam int N          = NUM_PANELS * COLS,
    localparam int CW         = clog2(NUM_PANELS * COLS)
) (
    input  logic                  Divided_CLK,
    input  logic                  RESET,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_addr,
    input  logic [ROWS-1:0]       wr_data,
    input  logic                  swap_req,
    input  logic [CW-1:0]         scroll,
    input  logic                  in_clr,
    output logic                  swap_pending,
    output logic                  frame_start,
    output logic [ROWS-1:0]       row_data,
    output logic                  column_clk,
    output logic                  column_first,
    output logic [NUM_PANELS-1:0] panel_sel_n,
    output logic                  out_clr
);

    localparam int  HW     = clog2(HOLD_CYCLES);
    localparam bit  REMAP  = REMAP_EN && (COLS == 8);

    scan_state_t   state;
    logic [CW-1:0] col;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] scroll_q;
    logic          bank_sel;
    logic          last_drive;
    logic          wr_ok;
    logic          rd_bank;
    logic [CW-1:0] scroll_eff;
    logic [CW:0]   sum;
    logic [CW-1:0] lcol;
    logic [CW-1:0] rd_addr;

    assign out_clr    = in_clr | RESET;
    assign last_drive = (state == DRIVE) && (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign wr_ok      = wr_en && (32'(wr_addr) < N);

    // Read address for the column about to be driven. In the boundary cycle
    // the read already belongs to the new frame, so it uses the bank and
    // scroll that take effect at the end of that cycle.
    always_comb begin
        rd_bank    = frame_start ? (bank_sel ^ swap_pending) : bank_sel;
        scroll_eff = frame_start ? scroll : scroll_q;
        sum        = {1'b0, col} + {1'b0, scroll_eff};
        lcol       = CW'(32'(sum) % N);
        rd_addr    = CW'((32'(lcol) / COLS) * COLS + remap_col(32'(lcol) % COLS, REMAP));
    end

    // Scan FSM with registered strobes, column/hold counters, scroll and swap.
    always_ff @(posedge Divided_CLK or posedge RESET) begin
        if (RESET) begin
            state        <= BLANK;
            col          <= '0;
            hold_cnt     <= '0;
            scroll_q     <= '0;
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
            frame_start  <= 1'b0;
            column_clk   <= 1'b0;
            column_first <= 1'b0;
            panel_sel_n  <= '1;
        end else begin
            case (state)
                BLANK: begin
                    state        <= DRIVE;
                    hold_cnt     <= '0;
                    frame_start  <= 1'b0;
                    column_clk   <= 1'b1;
                    column_first <= (col == '0);
                    panel_sel_n  <= ~(NUM_PANELS'(1) << (col / COLS));
                end
                DRIVE: begin
                    if (last_drive) begin
                        state        <= BLANK;
                        col          <= (col == CW'(N - 1)) ? '0 : col + 1'b1;
                        frame_start  <= (col == CW'(N - 1));
                        column_clk   <= 1'b0;
                        column_first <= 1'b0;
                        panel_sel_n  <= '1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase

            // frame_start is high exactly in the boundary cycle.
            if (frame_start) begin
                scroll_q     <= scroll;
                if (swap_pending) bank_sel <= ~bank_sel;
                swap_pending <= swap_pending ? 1'b0 : swap_req;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    dm_frame_buffer #(
        .N    (N),
        .ROWS (ROWS),
        .CW   (CW)
    ) u_fb (
        .Divided_CLK (Divided_CLK),
        .RESET       (RESET),
        .wr_en       (wr_ok),
        .wr_bank     (~bank_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .rd_load     (state == BLANK),
        .rd_clr      (last_drive),
        .rd_data     (row_data)
    );

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner (4 panels x 8 cols, 16 rows, hold 1).
// t counts falling edges since the last reset release; with one blank and
// one drive cycle per column, drive of col k in frame f is at t=64f+2k+1
// and the frame boundary of frame f is at t=64f.
module tb_matrix_scanner;

    logic        Divided_CLK;
    logic        RESET;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        swap_req;
    logic [4:0]  scroll;
    logic        in_clr;
    logic        swap_pending;
    logic        frame_start;
    logic [15:0] row_data;
    logic        column_clk;
    logic        column_first;
    logic [3:0]  panel_sel_n;
    logic        out_clr;

    int errors;
    int checks;
    int t;

    matrix_scanner dut (
        .Divided_CLK  (Divided_CLK),
        .RESET        (RESET),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .scroll       (scroll),
        .in_clr       (in_clr),
        .swap_pending (swap_pending),
        .frame_start  (frame_start),
        .row_data     (row_data),
        .column_clk   (column_clk),
        .column_first (column_first),
        .panel_sel_n  (panel_sel_n),
        .out_clr      (out_clr)
    );

    initial Divided_CLK = 1'b0;
    always #5 Divided_CLK = ~Divided_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (t < n) begin
            @(negedge Divided_CLK);
            t++;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".row"},   32'(row_data),     32'h0);
        chk({tag, ".clk"},   32'(column_clk),   32'h0);
        chk({tag, ".first"}, 32'(column_first), 32'h0);
        chk({tag, ".psel"},  32'(panel_sel_n),  32'hF);
        chk({tag, ".fs"},    32'(frame_start),  32'h0);
        chk({tag, ".pend"},  32'(swap_pending), 32'h0);
        chk({tag, ".clr"},   32'(out_clr),      32'h1);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        t        = 0;
        RESET    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        scroll   = '0;
        in_clr   = 1'b0;

        repeat (2) @(negedge Divided_CLK);
        chk_reset_outs("por");
        RESET = 1'b0;
        #1 chk("clr_idle", 32'(out_clr), 32'h0);
        in_clr = 1'b1;
        #1 chk("clr_ext", 32'(out_clr), 32'h1);
        in_clr = 1'b0;
        t = 0;

        // Preload: back bank1 with 0x0100+k, swap; then bank0 likewise, swap.
        for (int k = 0; k < 32; k++) begin
            goto(1 + k);
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 16'h0100 + 16'(k);
        end
        goto(33); wr_en = 1'b0; swap_req = 1'b1;
        goto(34); swap_req = 1'b0;
        chk("pre_pend", 32'(swap_pending), 32'h1);
        goto(65);
        chk("pre_bank1_c0", 32'(row_data), 32'h0107);
        for (int k = 0; k < 32; k++) begin
            goto(66 + k);
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 16'h0100 + 16'(k);
        end
        goto(98); wr_en = 1'b0; swap_req = 1'b1;
        goto(99); swap_req = 1'b0;
        goto(130);
        RESET = 1'b1;
        goto(132);
        chk_reset_outs("rst2");
        RESET = 1'b0;
        t = 0;

        // 1/2: first drive, blanking, panel selects, frame period.
        goto(1);
        chk("c0_row",   32'(row_data),     32'h0107);
        chk("c0_clk",   32'(column_clk),   32'h1);
        chk("c0_psel",  32'(panel_sel_n),  32'hE);
        chk("c0_first", 32'(column_first), 32'h1);
        goto(2);
        chk("blank_row",  32'(row_data),     32'h0);
        chk("blank_clk",  32'(column_clk),   32'h0);
        chk("blank_psel", 32'(panel_sel_n),  32'hF);
        chk("blank_first",32'(column_first), 32'h0);
        goto(3);
        chk("c1_row",   32'(row_data),     32'h0106);
        chk("c1_first", 32'(column_first), 32'h0);
        goto(17);
        chk("c8_row",  32'(row_data),    32'h010F);
        chk("c8_psel", 32'(panel_sel_n), 32'hD);
        goto(63);
        chk("c31_row",  32'(row_data),    32'h011B);
        chk("c31_psel", 32'(panel_sel_n), 32'h7);
        chk("fs_63",    32'(frame_start), 32'h0);
        goto(64);
        chk("fs_64",    32'(frame_start), 32'h1);
        chk("b64_row",  32'(row_data),    32'h0);
        goto(65);
        chk("fs_65",    32'(frame_start), 32'h0);
        chk("f1c0_row", 32'(row_data),    32'h0107);
        goto(128);
        chk("fs_128",   32'(frame_start), 32'h1);

        // 3: fill back bank with A5A5, swap mid-frame.
        for (int k = 0; k < 32; k++) begin
            goto(130 + k);
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 16'hA5A5;
        end
        goto(162); wr_en = 1'b0;
        goto(164); swap_req = 1'b1;
        goto(165); swap_req = 1'b0;
        chk("sw_pend", 32'(swap_pending), 32'h1);
        goto(169);
        chk("sw_old_c20", 32'(row_data), 32'h0110);
        goto(191);
        chk("sw_old_c31", 32'(row_data), 32'h011B);
        goto(192);
        chk("sw_pend_bnd", 32'(swap_pending), 32'h1);
        goto(193);
        chk("sw_new_c0", 32'(row_data), 32'hA5A5);
        goto(194);
        chk("sw_cleared", 32'(swap_pending), 32'h0);
        goto(219);
        chk("sw_new_c13", 32'(row_data), 32'hA5A5);

        // 4: request in the boundary cycle takes effect one frame later.
        goto(256);
        chk("co_fs", 32'(frame_start), 32'h1);
        swap_req = 1'b1;
        goto(257); swap_req = 1'b0;
        chk("co_pend", 32'(swap_pending), 32'h1);
        chk("co_nosw", 32'(row_data), 32'hA5A5);
        goto(320);
        chk("co_pend_bnd", 32'(swap_pending), 32'h1);
        goto(321);
        chk("co_sw_c0", 32'(row_data), 32'h0107);
        goto(322);
        chk("co_cleared", 32'(swap_pending), 32'h0);

        // 5: scroll latched only at the boundary.
        goto(330); scroll = 5'd5;
        goto(333);
        chk("sc_pre_c6", 32'(row_data), 32'h0105);
        goto(385);
        chk("sc_c0", 32'(row_data), 32'h0104);
        goto(437);
        chk("sc_c26", 32'(row_data), 32'h011B);
        goto(439);
        chk("sc_c27_wrap", 32'(row_data),    32'h0107);
        chk("sc_c27_psel", 32'(panel_sel_n), 32'h7);

        // 6: asynchronous reset during drive of col 13.
        goto(475);
        chk("mr_drive", 32'(column_clk), 32'h1);
        #2 RESET = 1'b1;
        #1 chk_reset_outs("mr");
        @(negedge Divided_CLK);
        @(negedge Divided_CLK);
        RESET = 1'b0;
        t = 0;
        goto(1);
        chk("mr_c0_row",   32'(row_data),     32'h0107);
        chk("mr_c0_first", 32'(column_first), 32'h1);
        goto(3);
        chk("mr_c1_row", 32'(row_data), 32'h0106);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
Name: matrix_scanner

Overview:
Parametrised column-scan driver for a multi-panel LED dot matrix. It holds two frames: a front bank that is displayed and a back bank that is written. The driver scans columns with a drive phase and a blanking phase, and selects panels one-hot active-low. It supports frame-synchronous bank swap and horizontal scroll. It sits between the pattern-loading logic and the external column shift registers and row drivers.

Parameters:
NUM_PANELS, 4, number of panels
COLS, 8, columns per panel
ROWS, 16, row bits per column word
HOLD_CYCLES, 1, Divided_CLK cycles per drive phase (>=1)
REMAP_EN, 1, apply panel wiring permutation (valid only when COLS==8)
Derived: N = NUM_PANELS*COLS; CW = clog2(N).

Ports:
Divided_CLK  in  1  scan/system clock
RESET  in  1  asynchronous, active-high reset
wr_en  in  1  write column word into back bank
wr_addr  in  CW  logical column address, 0..N-1
wr_data  in  ROWS  column pattern
swap_req  in  1  request front/back swap at next frame boundary
scroll  in  CW  horizontal offset, latched at frame boundary
in_clr  in  1  external clear
swap_pending  out  1  swap requested, not yet applied
frame_start  out  1  one-cycle pulse at frame boundary
row_data  out  ROWS  row drive for current column
column_clk  out  1  high during drive phase
column_first  out  1  high during drive of column 0
panel_sel_n  out  NUM_PANELS  active-low select of driven panel
out_clr  out  1  combinational in_clr | RESET

Behaviour:
- Reset values (asynchronous, immediate, also mid-frame):
  - row_data=0, column_clk=0, column_first=0, panel_sel_n=all 1, frame_start=0, swap_pending=0.
  - State=BLANK, col=0, bank select=0 (bank0 front), scroll_q=0.
  - Memory contents are not reset.
- FSM: BLANK (1 cycle) -> DRIVE (HOLD_CYCLES cycles) -> BLANK.
  - A hold counter counts the DRIVE cycles.
  - col increments at the end of each DRIVE and wraps N-1 -> 0.
  - The first DRIVE (col 0) starts in the second cycle after RESET deasserts.
- Read address:
  - Logical column L = (col + scroll_q) mod N.
  - Address = (L / COLS)*COLS + REMAP(L mod COLS).
  - REMAP = 0->7, 1->6, 2->1, 3->2, 4->0, 5->4, 6->5, 7->3 when REMAP_EN; identity otherwise.
  - Read is synchronous: the address is issued in BLANK, so data is valid on the first DRIVE cycle.
- DRIVE outputs:
  - row_data = front[addr].
  - column_clk=1.
  - panel_sel_n[col/COLS]=0, other bits 1.
  - column_first=(col==0).
- BLANK outputs: row_data=0, column_clk=0, panel_sel_n=all 1, column_first=0.
- Frame boundary: the BLANK cycle following DRIVE of col N-1.
  - frame_start=1 in that cycle.
  - scroll_q<=scroll.
  - If swap_pending: bank select toggles and swap_pending clears.
- Swap request handling:
  - swap_req sets swap_pending on the next edge.
  - A request coincident with the boundary cycle is applied at the following boundary.
  - swap_req while already pending has no effect.
- Writes:
  - wr_en writes the bank that is back at the start of the cycle, including the swap cycle.
  - wr_addr >= N is ignored.
  - Writes never affect the front bank.
  - Same-address read/write conflicts cannot occur, because reads and writes target different banks.
- Period: one frame = N*(HOLD_CYCLES+1) cycles.

Decomposition:
- Package dotmatrix_pkg: clog2 function, REMAP constant function, scan-state enum (BLANK, DRIVE).
- Sub-module dm_frame_buffer: two banks of N x ROWS, one write port to the back bank, one synchronous read port from the front bank, bank-select input.
- matrix_scanner contains the FSM, counters, scroll/swap logic and the output registers.

Test Plan:
1. Reset release, defaults, bank0 written with col k = 16'h0100+k:
   - First DRIVE shows col 0 with row_data = word REMAP(0)=7, i.e. 16'h0107.
   - panel_sel_n=4'b1110, column_first=1.
   - frame_start pulses every 64 cycles.
2. Blanking:
   - Every BLANK cycle has row_data=0, column_clk=0, panel_sel_n=4'hF.
   - DRIVE of col 8 gives panel_sel_n=4'b1101; col 31 gives 4'b0111.
3. Swap:
   - Write the back bank with 16'hA5A5 everywhere, pulse swap_req mid-frame.
   - swap_pending=1 until the boundary.
   - The next frame displays 16'hA5A5 on all columns; the prior frame is unchanged.
4. Swap coincident with boundary:
   - swap_req asserted in the frame_start cycle.
   - The swap occurs one frame later.
5. Scroll:
   - Set scroll=5 mid-frame; there is no change until the boundary.
   - In the next frame, col 0 reads logical column 5, i.e. word REMAP(5)=4 (16'h0104).
   - Also check wrap: col 27 reads logical column 0.
6. Mid-frame RESET:
   - Assert RESET during DRIVE of col 13.
   - Outputs go to reset values the same instant; out_clr=1.
   - The scan restarts at col 0 after release, and memory contents are preserved.
